inst_dispatch: RTL and testbench

INST_DISPATCH -- requirements
Module: inst_dispatch

---
 rtl/frodo_inst_pkg.sv | 27 ++
 rtl/inst_fifo.sv | 61 ++++++
 rtl/inst_dispatch.sv | 130 +++++++++++++
 tb/tb_inst_dispatch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frodo_inst_pkg.sv
// Shared instruction layout, dispatcher state encoding and legality rule for the
// instruction dispatcher and its queue.
package frodo_inst_pkg;

  localparam int INST_WIDTH = 27;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [3:0]  a_idx;
    logic [3:0]  b_idx;
    logic [3:0]  c_idx;
    logic        mode;
    logic [10:0] rsvd;
  } inst_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Opcode 0 is reserved as a no-op trap and the reserved field must be clear.
  function automatic logic is_legal(inst_t w);
    return (w.opcode != 3'b000) && (w.rsvd == 11'd0);
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO, DEPTH x WIDTH, head word visible combinationally; 1-cycle write-to-read.
// Full blocks pushes, clear discards everything and overrides a same-cycle push/pop.
module inst_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  input  logic                     i_clr,
  output logic [WIDTH-1:0]         o_head_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

  assign w_do_push = i_push && !o_full && !i_clr;
  assign w_do_pop  = i_pop && !o_empty && !i_clr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/inst_dispatch.sv
// Queues host instructions and issues one at a time to the core, waiting for exec_done.
// Push-to-issue 2 edges; in_ready drops only when the queue is full; HALT stops issue until clr_err.
module inst_dispatch
  import frodo_inst_pkg::*;
#(
  parameter int INST_WIDTH = frodo_inst_pkg::INST_WIDTH,
  parameter int DEPTH      = 8,
  parameter int TIME       = 100000
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [INST_WIDTH-1:0]   in_inst,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [INST_WIDTH-1:0]   inst,
  output logic                    inst_valid,
  input  logic                    exec_done,
  input  logic                    flush,
  input  logic                    clr_err,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [15:0]             issued_cnt,
  output logic                    err_illegal,
  output logic                    err_timeout
);

  localparam int TW = $clog2(TIME + 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [INST_WIDTH-1:0]   r_inst;
  logic                    r_inst_valid;
  logic [15:0]             r_issued;
  logic                    r_err_ill;
  logic                    r_err_tmo;
  logic [TW-1:0]           r_tmo;

  logic                    w_full;
  logic                    w_empty;
  logic [INST_WIDTH-1:0]   w_head;
  logic                    w_push;
  logic                    w_legal;
  logic                    w_exec_ok;
  logic                    w_tmo_hit;
  logic                    w_pop;
  logic                    w_issue;
  logic                    w_set_ill;
  logic                    w_set_tmo;

  inst_fifo #(
    .WIDTH (INST_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .i_push     (w_push),
    .i_push_dat (in_inst),
    .i_pop      (w_pop),
    .i_clr      (flush),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (fifo_count)
  );

  assign w_push  = in_valid && !w_full;
  assign w_legal = is_legal(w_head);

  // The strobe cycle itself is too early for a genuine completion, so it is masked.
  assign w_exec_ok = (r_state == ST_WAIT) && exec_done && !r_inst_valid;
  assign w_tmo_hit = (r_state == ST_WAIT) && !w_exec_ok && (r_tmo == TW'(TIME - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pop && w_legal) w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (w_exec_ok)      w_state_nxt = ST_IDLE;
        else if (w_tmo_hit) w_state_nxt = ST_HALT;
      end
      ST_HALT: if (clr_err) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A flush in the same cycle wins over the head pop: the head is still unissued.
  always_comb begin
    w_pop     = (r_state == ST_IDLE) && !w_empty && !flush;
    w_issue   = w_pop && w_legal;
    w_set_ill = w_pop && !w_legal;
    w_set_tmo = w_tmo_hit;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_issued     <= 16'd0;
      r_tmo        <= '0;
      r_err_ill    <= 1'b0;
      r_err_tmo    <= 1'b0;
    end else begin
      r_inst_valid <= w_issue;
      if (w_issue) begin
        r_inst   <= w_head;
        r_issued <= r_issued + 16'd1;
      end
      if (w_issue)                    r_tmo <= '0;
      else if (r_state == ST_WAIT)    r_tmo <= r_tmo + 1'b1;
      if (w_set_ill)    r_err_ill <= 1'b1;
      else if (clr_err) r_err_ill <= 1'b0;
      if (w_set_tmo)    r_err_tmo <= 1'b1;
      else if (clr_err) r_err_tmo <= 1'b0;
    end
  end

  assign in_ready    = !w_full;
  assign inst        = r_inst;
  assign inst_valid  = r_inst_valid;
  assign busy        = (r_state != ST_IDLE);
  assign issued_cnt  = r_issued;
  assign err_illegal = r_err_ill;
  assign err_timeout = r_err_tmo;

endmodule

// File: tb/tb_inst_dispatch.sv
// Randomised scoreboard bench for inst_dispatch against a queue-based reference model.
module tb_inst_dispatch;

  localparam int DEPTH = 8;
  localparam int TIME  = 20;

  logic        clk;
  logic        rstn;
  logic [26:0] in_inst;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] inst;
  logic        inst_valid;
  logic        exec_done;
  logic        flush;
  logic        clr_err;
  logic        busy;
  logic [3:0]  fifo_count;
  logic [15:0] issued_cnt;
  logic        err_illegal;
  logic        err_timeout;

  inst_dispatch #(.INST_WIDTH(27), .DEPTH(DEPTH), .TIME(TIME)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_inst     (in_inst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .exec_done   (exec_done),
    .flush       (flush),
    .clr_err     (clr_err),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .issued_cnt  (issued_cnt),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic bit legal(logic [26:0] w);
    return (w[26:24] != 3'b000) && (w[10:0] == 11'd0);
  endfunction

  function automatic logic [26:0] gen_word();
    logic [26:0] w;
    int r;
    r = $urandom_range(0, 9);
    w = {3'($urandom_range(1, 7)), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 11'd0};
    if (r == 0)      w[26:24] = 3'b000;
    else if (r == 1) w[10:0]  = 11'($urandom_range(1, 2047));
    return w;
  endfunction

  // Reference model: a plain queue of pending words plus "waiting"/"halted" flags.
  logic [26:0] mq[$];
  logic [26:0] sb[$];
  bit          m_wait, m_halt, m_vld, m_eill, m_etmo;
  int          m_age;
  logic [26:0] m_inst;
  logic [15:0] m_cnt;

  always @(posedge clk or negedge rstn) begin
    bit          full_pre, set_i, set_t, nv;
    logic [26:0] w;
    if (!rstn) begin
      mq.delete(); sb.delete();
      m_wait = 0; m_halt = 0; m_vld = 0; m_eill = 0; m_etmo = 0;
      m_age = 0; m_inst = '0; m_cnt = '0;
    end else begin
      full_pre = (mq.size() == DEPTH);
      set_i = 0; set_t = 0; nv = 0;
      if (!m_wait && !m_halt) begin
        if (mq.size() > 0 && !flush) begin
          w = mq.pop_front();
          if (legal(w)) begin
            m_inst = w; nv = 1; m_cnt++; m_wait = 1; m_age = 0;
            sb.push_back(w);
          end else set_i = 1;
        end
      end else if (m_wait) begin
        m_age++;
        if (exec_done && !m_vld) m_wait = 0;
        else if (m_age >= TIME) begin
          m_wait = 0; m_halt = 1; set_t = 1;
        end
      end else if (clr_err) m_halt = 0;
      m_eill = set_i | (m_eill & !clr_err);
      m_etmo = set_t | (m_etmo & !clr_err);
      if (flush) mq.delete();
      else if (in_valid && !full_pre) mq.push_back(in_inst);
      m_vld = nv;
    end
  end

  // Monitor: every issue strobe must match the oldest expected issue.
  bit prev_vld;
  always @(negedge clk) begin
    if (!rstn) prev_vld = 0;
    else begin
      if (inst_valid) begin
        chk("strobe_gap", prev_vld, 0);
        if (sb.size() == 0) chk("unexpected_issue", inst_valid, 0);
        else chk("issue_word", inst, sb.pop_front());
      end
      prev_vld = inst_valid;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("cyc_inst_valid", inst_valid, m_vld);
      chk("cyc_inst", inst, m_inst);
      chk("cyc_fifo_count", fifo_count, mq.size());
      chk("cyc_in_ready", in_ready, mq.size() < DEPTH);
      chk("cyc_busy", busy, m_wait || m_halt);
      chk("cyc_issued_cnt", issued_cnt, m_cnt);
      chk("cyc_err_illegal", err_illegal, m_eill);
      chk("cyc_err_timeout", err_timeout, m_etmo);
    end
  end

  task automatic push_word(input logic [26:0] w);
    int b = 0;
    in_inst = w; in_valid = 1'b1;
    while (!in_ready && b < 40) begin @(negedge clk); b++; end
    if (b >= 40) chk("push_ready_timeout", in_ready, 1);
    @(negedge clk);
  endtask

  task automatic wait_vld();
    int b = 0;
    while (!inst_valid && b < 60) begin @(negedge clk); b++; end
    chk("wait_issue", b < 60, 1);
  endtask

  task automatic finish_inst();
    int b = 0;
    while (!(m_wait && !m_vld) && b < 60) begin @(negedge clk); b++; end
    chk("wait_for_wait_state", b < 60, 1);
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_inst = '0; in_valid = 0; exec_done = 0; flush = 0; clr_err = 0; rstn = 0;
    repeat (3) @(negedge clk);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {err_illegal, err_timeout}, 0);
    @(posedge clk); #2 rstn = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_no_strobe", inst_valid, 0);

    // Single legal word: strobe exactly one cycle, two edges after the push.
    push_word(27'h4123000); in_valid = 0;
    chk("t1_pre_strobe", inst_valid, 0);
    @(negedge clk);
    chk("t1_strobe", inst_valid, 1);
    chk("t1_inst", inst, 27'h4123000);
    chk("t1_busy", busy, 1);
    chk("t1_issued", issued_cnt, 1);
    @(negedge clk);
    chk("t1_strobe_off", inst_valid, 0);
    finish_inst();
    @(negedge clk);
    chk("t1_idle", busy, 0);

    // Illegal word dropped, following legal word issued.
    push_word(27'h4123001);
    push_word(27'h5030000); in_valid = 0;
    wait_vld();
    chk("t2_inst", inst, 27'h5030000);
    chk("t2_err_illegal", err_illegal, 1);
    finish_inst();
    clr_err = 1; @(negedge clk); clr_err = 0;
    chk("t2_err_cleared", err_illegal, 0);

    // Nine back-to-back words with no completion fill the queue.
    for (int i = 0; i < 9; i++) push_word({3'd1 + 3'(i % 7), 4'(i), 4'(i + 1), 4'(i + 2), 1'b0, 11'd0});
    in_valid = 0;
    chk("t3_full_count", fifo_count, 8);
    chk("t3_full_ready", in_ready, 0);
    for (int i = 0; i < 9; i++) finish_inst();
    repeat (3) @(negedge clk);
    chk("t3_drained", fifo_count, 0);

    // Timeout to HALT; queued word waits for clr_err.
    push_word(27'h6000000);
    push_word(27'h7100000); in_valid = 0;
    wait_vld();
    repeat (19) @(negedge clk);
    chk("t4_no_tmo_yet", err_timeout, 0);
    @(negedge clk);
    chk("t4_tmo", err_timeout, 1);
    chk("t4_busy_halt", busy, 1);
    repeat (5) @(negedge clk);
    chk("t4_held_count", fifo_count, 1);
    exec_done = 1; @(negedge clk); exec_done = 0;
    chk("t4_done_ignored_halt", busy, 1);
    clr_err = 1; @(negedge clk); clr_err = 0;
    wait_vld();
    chk("t4_after_clr", inst, 27'h7100000);
    chk("t4_tmo_cleared", err_timeout, 0);
    finish_inst();

    // Flush while waiting.
    push_word(27'h2000000);
    push_word(27'h2100000);
    push_word(27'h2200000);
    push_word(27'h2300000); in_valid = 0;
    chk("t5_queued", fifo_count, 3);
    flush = 1; @(negedge clk); flush = 0;
    chk("t5_flushed", fifo_count, 0);
    chk("t5_still_wait", busy, 1);
    finish_inst();
    repeat (5) @(negedge clk);
    chk("t5_idle", busy, 0);

    // Asynchronous reset mid-WAIT with four queued.
    for (int i = 0; i < 5; i++) push_word({3'd3, 4'(i), 8'h00, 1'b1, 11'd0});
    in_valid = 0;
    @(posedge clk); #3 rstn = 0; #1;
    chk("t6_rst_valid", inst_valid, 0);
    chk("t6_rst_inst", inst, 0);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_issued", issued_cnt, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rstn = 1;
    @(negedge clk);
    chk("t6_rel_valid", inst_valid, 0);
    chk("t6_rel_ready", in_ready, 1);
    chk("t6_rel_count", fifo_count, 0);

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_inst   = gen_word();
      exec_done = ((c % 400) >= 40) && ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 49) == 0);
      clr_err   = ($urandom_range(0, 11) == 0);
      @(negedge clk);
    end
    in_valid = 0; flush = 0;
    for (int c = 0; c < 300; c++) begin
      exec_done = m_wait && !m_vld;
      clr_err   = m_halt;
      @(negedge clk);
    end
    exec_done = 0; clr_err = 0;
    @(negedge clk);
    chk("end_fifo_count", fifo_count, 0);
    chk("end_busy", busy, 0);
    chk("end_scoreboard", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
